// File: rtl/input_vc_buf_pkg.sv
// Shared flit format, type codes, VC FSM states and sizing for the input VC buffer.
package input_vc_buf_pkg;

  localparam int unsigned DATAW         = 32;
  localparam int unsigned TYPE_W        = 2;
  localparam int unsigned VCH_W         = 2;
  localparam int unsigned PAYLOAD_W     = DATAW - TYPE_W - VCH_W;
  localparam int unsigned BUF_DEPTH_DEF = 4;
  localparam int unsigned VCH_NUM_DEF   = 2;

  typedef enum logic [TYPE_W-1:0] {
    FT_HEAD     = 2'd0,
    FT_BODY     = 2'd1,
    FT_TAIL     = 2'd2,
    FT_HEADTAIL = 2'd3
  } flit_type_e;

  // Type lives in the top bits, then the VC id, then the payload.
  typedef struct packed {
    flit_type_e           ftype;
    logic [VCH_W-1:0]     vc;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

  typedef enum logic [1:0] {
    VC_IDLE   = 2'd0,
    VC_RC     = 2'd1,
    VC_ACTIVE = 2'd2
  } vc_state_e;

  // A flit that may open a packet.
  function automatic logic is_head(input flit_type_e t);
    return (t == FT_HEAD) || (t == FT_HEADTAIL);
  endfunction

  // A flit that closes a packet.
  function automatic logic is_tail(input flit_type_e t);
    return (t == FT_TAIL) || (t == FT_HEADTAIL);
  endfunction

endpackage

// File: rtl/input_vc_buf_if.sv
// Link, route-compute, switch-allocator and crossbar signals of one input port.
interface input_vc_buf_if
  import input_vc_buf_pkg::*;
#(
  parameter int unsigned VCH_NUM = VCH_NUM_DEF
) ();

  flit_t                  idata;
  logic                   ivalid;
  flit_t [VCH_NUM-1:0]    bdata_vc;
  logic  [VCH_NUM-1:0]    rt_en;
  logic  [VCH_NUM-1:0]    sw_req;
  logic  [VCH_NUM-1:0]    sw_gnt;
  flit_t                  odata;
  logic                   ovalid;
  logic  [VCH_NUM-1:0]    ocredit;
  logic                   ovf;

  // Buffer side.
  modport slave (
    input  idata, ivalid, sw_gnt,
    output bdata_vc, rt_en, sw_req, odata, ovalid, ocredit, ovf
  );

  // Upstream link / allocator side.
  modport master (
    output idata, ivalid, sw_gnt,
    input  bdata_vc, rt_en, sw_req, odata, ovalid, ocredit, ovf
  );

endinterface

// File: rtl/input_vc_buf_vc_fifo.sv
// Single-VC flit FIFO with wrap-bit pointers and a combinational front entry.
module input_vc_buf_vc_fifo
  import input_vc_buf_pkg::*;
#(
  parameter int unsigned DEPTH = BUF_DEPTH_DEF
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  wr_en,
  input  flit_t wr_data,
  input  logic  rd_en,
  output logic  full,
  output logic  empty,
  output logic  empty_nxt,
  output flit_t front
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_nxt;
  logic [PW-1:0] rd_ptr_nxt;
  logic          do_wr;
  logic          do_rd;
  flit_t         mem [DEPTH];

  // Status, accept decisions and next pointers; a read frees the slot a full write needs.
  always_comb begin
    empty      = (wr_ptr == rd_ptr);
    full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_rd      = rd_en && !empty;
    do_wr      = wr_en && (!full || do_rd);
    wr_ptr_nxt = do_wr ? wr_ptr + PW'(1) : wr_ptr;
    rd_ptr_nxt = do_rd ? rd_ptr + PW'(1) : rd_ptr;
    empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
    front      = empty ? '0 : mem[rd_ptr[AW-1:0]];
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
    end
  end

  // Flit storage; contents are meaningless until the pointers say otherwise.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/input_vc_buf.sv
// Router input port: per-VC FIFOs, per-VC IDLE/RC/ACTIVE control, switch request and dequeue.
module input_vc_buf
  import input_vc_buf_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = BUF_DEPTH_DEF,
  parameter int unsigned VCH_NUM   = VCH_NUM_DEF
) (
  input logic           clk,
  input logic           rst_n,
  input_vc_buf_if.slave bus
);

  flit_t              front     [VCH_NUM];
  vc_state_e          state_q   [VCH_NUM];
  vc_state_e          state_d   [VCH_NUM];
  logic [VCH_NUM-1:0] wr_en;
  logic [VCH_NUM-1:0] rd_en;
  logic [VCH_NUM-1:0] full;
  logic [VCH_NUM-1:0] empty;
  logic [VCH_NUM-1:0] empty_nxt;
  logic [VCH_NUM-1:0] discard;
  logic [VCH_NUM-1:0] req_c;
  logic [VCH_NUM-1:0] gnt_c;
  logic [VCH_NUM-1:0] deq;
  flit_t              deq_flit;
  logic               drop;

  logic [VCH_NUM-1:0] rt_en_q;
  logic [VCH_NUM-1:0] sw_req_q;
  logic [VCH_NUM-1:0] ocredit_q;
  flit_t              odata_q;
  logic               ovalid_q;
  logic               ovf_q;

  for (genvar v = 0; v < VCH_NUM; v++) begin : g_vc
    input_vc_buf_vc_fifo #(
      .DEPTH (BUF_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en[v]),
      .wr_data   (bus.idata),
      .rd_en     (rd_en[v]),
      .full      (full[v]),
      .empty     (empty[v]),
      .empty_nxt (empty_nxt[v]),
      .front     (front[v])
    );
  end

  // Steer the incoming flit to the FIFO named by its VC field.
  always_comb begin
    wr_en = '0;
    for (int unsigned v = 0; v < VCH_NUM; v++) begin
      wr_en[v] = bus.ivalid && (bus.idata.vc == VCH_W'(v));
    end
  end

  // Requests, lowest-index grant filter, and discard of stray BODY/TAIL at an idle VC.
  always_comb begin
    req_c   = '0;
    discard = '0;
    for (int unsigned v = 0; v < VCH_NUM; v++) begin
      req_c[v]   = (state_q[v] == VC_ACTIVE) && !empty[v];
      discard[v] = (state_q[v] == VC_IDLE) && !empty[v] && !is_head(front[v].ftype);
    end
    gnt_c = bus.sw_gnt & req_c;
    deq   = gnt_c & (~gnt_c + VCH_NUM'(1));
    rd_en = deq | discard;
  end

  // Select the flit leaving through the crossbar and detect dropped writes.
  always_comb begin
    deq_flit = '0;
    for (int unsigned v = 0; v < VCH_NUM; v++) begin
      if (deq[v]) begin
        deq_flit = front[v];
      end
    end
    drop = |(wr_en & full & ~rd_en);
  end

  // Per-VC state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned v = 0; v < VCH_NUM; v++) begin
        state_q[v] <= VC_IDLE;
      end
    end else begin
      for (int unsigned v = 0; v < VCH_NUM; v++) begin
        state_q[v] <= state_d[v];
      end
    end
  end

  // Per-VC next state: a head opens route compute, a dequeued tail closes the packet.
  always_comb begin
    for (int unsigned v = 0; v < VCH_NUM; v++) begin
      state_d[v] = state_q[v];
      case (state_q[v])
        VC_IDLE: begin
          if (!empty[v] && is_head(front[v].ftype)) begin
            state_d[v] = VC_RC;
          end
        end
        VC_RC: begin
          state_d[v] = VC_ACTIVE;
        end
        VC_ACTIVE: begin
          if (deq[v] && is_tail(front[v].ftype)) begin
            state_d[v] = VC_IDLE;
          end
        end
        default: begin
          state_d[v] = VC_IDLE;
        end
      endcase
    end
  end

  // Output registers, loaded from next-state values so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rt_en_q   <= '0;
      sw_req_q  <= '0;
      ocredit_q <= '0;
      odata_q   <= '0;
      ovalid_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      for (int unsigned v = 0; v < VCH_NUM; v++) begin
        rt_en_q[v]  <= (state_d[v] == VC_RC);
        sw_req_q[v] <= (state_d[v] == VC_ACTIVE) && !empty_nxt[v];
      end
      ocredit_q <= rd_en;
      odata_q   <= deq_flit;
      ovalid_q  <= |deq;
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Drive the port bundle.
  always_comb begin
    for (int unsigned v = 0; v < VCH_NUM; v++) begin
      bus.bdata_vc[v] = front[v];
    end
    bus.rt_en   = rt_en_q;
    bus.sw_req  = sw_req_q;
    bus.ocredit = ocredit_q;
    bus.odata   = odata_q;
    bus.ovalid  = ovalid_q;
    bus.ovf     = ovf_q;
  end

endmodule

// File: tb/tb_input_vc_buf.sv
// Bench for input_vc_buf: directed scenarios plus random traffic against a queue-based model.
module tb_input_vc_buf;
  import input_vc_buf_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned NVC   = 2;
  localparam int M_IDLE  = 0;
  localparam int M_ROUTE = 1;
  localparam int M_FWD   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  input_vc_buf_if #(.VCH_NUM(NVC)) bus ();

  input_vc_buf #(
    .BUF_DEPTH (DEPTH),
    .VCH_NUM   (NVC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model: one queue and one packet mode per VC, plus expected registered outputs.
  flit_t          q [NVC][$];
  int             mode [NVC];
  logic [NVC-1:0] e_rt;
  logic [NVC-1:0] e_req;
  logic [NVC-1:0] e_cr;
  flit_t          e_odata;
  logic           e_ov;
  logic           e_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic flit_t mk(input flit_type_e t, input int vc, input int pl);
    flit_t f;
    f.ftype   = t;
    f.vc      = VCH_W'(vc);
    f.payload = PAYLOAD_W'(pl);
    return f;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NVC; v++) begin
      q[v].delete();
      mode[v] = M_IDLE;
    end
    e_rt = '0; e_req = '0; e_cr = '0; e_odata = '0; e_ov = 1'b0; e_ovf = 1'b0;
  endtask

  // Apply one clock edge's worth of behaviour using the inputs currently driven.
  task automatic model_edge();
    int    g;
    int    nm [NVC];
    flit_t fr;
    int    vc;
    g = -1;
    for (int v = 0; v < NVC; v++) begin
      if (mode[v] == M_FWD && q[v].size() > 0 && bus.sw_gnt[v] && g < 0) g = v;
    end
    e_ov    = (g >= 0);
    e_odata = '0;
    if (g >= 0) e_odata = q[g][0];
    e_cr = '0;
    for (int v = 0; v < NVC; v++) begin
      nm[v] = mode[v];
      if (mode[v] == M_ROUTE) nm[v] = M_FWD;
      if (q[v].size() > 0) begin
        fr = q[v][0];
        if (mode[v] == M_IDLE) begin
          if (is_head(fr.ftype)) nm[v] = M_ROUTE;
          else begin
            void'(q[v].pop_front());
            e_cr[v] = 1'b1;
          end
        end else if (mode[v] == M_FWD && v == g) begin
          void'(q[v].pop_front());
          e_cr[v] = 1'b1;
          if (is_tail(fr.ftype)) nm[v] = M_IDLE;
        end
      end
    end
    if (bus.ivalid) begin
      vc = int'(bus.idata.vc);
      if (vc < NVC) begin
        if (q[vc].size() < DEPTH) q[vc].push_back(bus.idata);
        else e_ovf = 1'b1;
      end
    end
    for (int v = 0; v < NVC; v++) begin
      mode[v]  = nm[v];
      e_rt[v]  = (mode[v] == M_ROUTE);
      e_req[v] = (mode[v] == M_FWD) && (q[v].size() > 0);
    end
  endtask

  task automatic check_all();
    flit_t ef;
    chk("rt_en",   64'(bus.rt_en),   64'(e_rt));
    chk("sw_req",  64'(bus.sw_req),  64'(e_req));
    chk("ocredit", 64'(bus.ocredit), 64'(e_cr));
    chk("ovalid",  64'(bus.ovalid),  64'(e_ov));
    chk("odata",   64'(bus.odata),   64'(e_odata));
    chk("ovf",     64'(bus.ovf),     64'(e_ovf));
    for (int v = 0; v < NVC; v++) begin
      ef = '0;
      if (q[v].size() > 0) ef = q[v][0];
      chk($sformatf("bdata_vc%0d", v), 64'(bus.bdata_vc[v]), 64'(ef));
    end
  endtask

  // One clock: drive at the falling edge, model at the rising edge, check at the next falling edge.
  task automatic cycle(input logic iv, input flit_t d, input logic [NVC-1:0] gnt);
    bus.ivalid = iv;
    bus.idata  = d;
    bus.sw_gnt = gnt;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    bus.ivalid = 1'b0;
    bus.idata  = '0;
    bus.sw_gnt = '0;
    rst_n      = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    flit_t pkt [4];
    flit_t f;
    int    ov_cnt;
    int    rt_cnt;
    int    cr_cnt;

    do_reset();

    // Single HEADTAIL on VC0 with a standing grant: latency chain.
    f = mk(FT_HEADTAIL, 0, 'h1234);
    cycle(1'b1, f, 2'b01);
    chk("ht_t0_rt", 64'(bus.rt_en), 64'(2'b00));
    cycle(1'b0, '0, 2'b01);
    chk("ht_t1_rt", 64'(bus.rt_en), 64'(2'b01));
    cycle(1'b0, '0, 2'b01);
    chk("ht_t2_req", 64'(bus.sw_req), 64'(2'b01));
    cycle(1'b0, '0, 2'b01);
    chk("ht_t3_odata", 64'(bus.odata), 64'(f));
    chk("ht_t3_cr", 64'(bus.ocredit), 64'(2'b01));
    chk("ht_t3_req", 64'(bus.sw_req), 64'(2'b00));
    cycle(1'b0, '0, 2'b01);

    // Four-flit packet on VC1 with grants every cycle.
    pkt[0] = mk(FT_HEAD, 1, 1);
    pkt[1] = mk(FT_BODY, 1, 2);
    pkt[2] = mk(FT_BODY, 1, 3);
    pkt[3] = mk(FT_TAIL, 1, 4);
    ov_cnt = 0; rt_cnt = 0; cr_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      f = '0;
      if (i < 4) f = pkt[i];
      cycle(i < 4, f, 2'b10);
      if (bus.ovalid) begin
        chk("pkt_order", 64'(bus.odata), 64'(pkt[ov_cnt % 4]));
        ov_cnt++;
      end
      if (bus.rt_en[1]) rt_cnt++;
      if (bus.ocredit[1]) cr_cnt++;
    end
    chk("pkt_ovalid_pulses", 64'(ov_cnt), 64'(4));
    chk("pkt_rt_pulses",     64'(rt_cnt), 64'(1));
    chk("pkt_credit_pulses", 64'(cr_cnt), 64'(4));

    // Overflow on VC0, then simultaneous write and dequeue on the full VC.
    do_reset();
    cycle(1'b1, mk(FT_HEAD, 0, 10), 2'b00);
    for (int i = 1; i < 5; i++) cycle(1'b1, mk(FT_BODY, 0, 10 + i), 2'b00);
    chk("ovf_set", 64'(bus.ovf), 64'(1));
    chk("ovf_front", 64'(bus.bdata_vc[0]), 64'(mk(FT_HEAD, 0, 10)));
    cycle(1'b1, mk(FT_TAIL, 0, 15), 2'b01);
    chk("full_rw_ovalid", 64'(bus.ovalid), 64'(1));
    chk("full_rw_ovf", 64'(bus.ovf), 64'(1));
    chk("full_rw_front", 64'(bus.bdata_vc[0]), 64'(mk(FT_BODY, 0, 11)));
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 2'b01);

    // Both VCs active with a multi-hot grant: only VC0 served.
    do_reset();
    cycle(1'b1, mk(FT_HEAD, 0, 20), 2'b00);
    cycle(1'b1, mk(FT_HEAD, 1, 21), 2'b00);
    cycle(1'b0, '0, 2'b00);
    cycle(1'b0, '0, 2'b00);
    chk("both_req", 64'(bus.sw_req), 64'(2'b11));
    cycle(1'b0, '0, 2'b11);
    chk("multigrant_cr", 64'(bus.ocredit), 64'(2'b01));
    chk("multigrant_odata", 64'(bus.odata), 64'(mk(FT_HEAD, 0, 20)));

    // Stray BODY at an idle VC is dropped with a credit.
    do_reset();
    cycle(1'b1, mk(FT_BODY, 0, 30), 2'b01);
    cycle(1'b0, '0, 2'b01);
    chk("stray_cr", 64'(bus.ocredit), 64'(2'b01));
    chk("stray_ovalid", 64'(bus.ovalid), 64'(0));
    chk("stray_rt", 64'(bus.rt_en), 64'(2'b00));
    cycle(1'b0, '0, 2'b01);

    // Reset with three flits of a packet buffered.
    do_reset();
    cycle(1'b1, mk(FT_HEAD, 1, 40), 2'b00);
    cycle(1'b1, mk(FT_BODY, 1, 41), 2'b00);
    cycle(1'b1, mk(FT_BODY, 1, 42), 2'b00);
    chk("pre_rst_req", 64'(bus.sw_req), 64'(2'b10));
    bus.ivalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_odata",   64'(bus.odata),   64'(0));
    chk("rst_ovalid",  64'(bus.ovalid),  64'(0));
    chk("rst_ocredit", 64'(bus.ocredit), 64'(2'b00));
    chk("rst_rt",      64'(bus.rt_en),   64'(2'b00));
    chk("rst_req",     64'(bus.sw_req),  64'(2'b00));
    chk("rst_ovf",     64'(bus.ovf),     64'(0));
    chk("rst_front1",  64'(bus.bdata_vc[1]), 64'(0));
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 2'b11);
      chk("post_rst_req", 64'(bus.sw_req), 64'(2'b00));
      chk("post_rst_cr", 64'(bus.ocredit), 64'(2'b00));
    end

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      f.ftype   = flit_type_e'($urandom_range(0, 3));
      f.vc      = VCH_W'($urandom_range(0, NVC - 1));
      f.payload = PAYLOAD_W'($urandom);
      cycle($urandom_range(0, 9) < 6, f, NVC'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/input_vc_buf.md
INPUT_VC_BUF -- requirements
Module: input_vc_buf

Interface
REQ-001: Parameter BUF_DEPTH, default 4: flit entries per VC FIFO (power of two, >=2).
REQ-002: Parameter VCH_NUM, default 2: virtual channels per input port.
REQ-003: clk  input  1  single clock; all state on rising edge.
REQ-004: rst_  input  1  reset, asynchronous, active-low.
REQ-005: idata  input  [`DATAW:0]  incoming flit from upstream link; VC id in [`VCH_MSB:`VCH_LSB], flit type in [`TYPE_MSB:`TYPE_LSB].
REQ-006: ivalid  input  1  idata valid this cycle.
REQ-007: bdata_vc  output  VCH_NUM x [`DATAW:0]  front flit of each VC FIFO, to per-VC route computation.
REQ-008: rt_en  output  [VCH_NUM-1:0]  one-cycle route-compute enable per VC.
REQ-009: sw_req  output  [VCH_NUM-1:0]  per-VC request to switch allocator.
REQ-010: sw_gnt  input  [VCH_NUM-1:0]  one-hot grant from switch allocator.
REQ-011: odata  output  [`DATAW:0]  registered dequeued flit to crossbar.
REQ-012: ovalid  output  1  odata valid.
REQ-013: ocredit  output  [VCH_NUM-1:0]  one-cycle credit return per VC to upstream.
REQ-014: ovf  output  1  sticky overflow error flag.

Function
REQ-015: ivalid=1 SHALL write idata into the FIFO selected by its VC field at the rising edge.
REQ-016: Write to a full FIFO with no same-cycle dequeue on that VC SHALL be dropped and SHALL set ovf until reset.
REQ-017: Write and dequeue on the same full VC in one cycle SHALL both succeed; occupancy unchanged.
REQ-018: Read/write pointers SHALL wrap modulo BUF_DEPTH; full/empty distinguished by an extra pointer MSB.
REQ-019: bdata_vc[v] SHALL show the FIFO front entry combinationally; value undefined-but-stable (zero) when empty.
REQ-020: Per-VC FSM states: IDLE, RC, ACTIVE.
REQ-021: IDLE -> RC when FIFO non-empty and front type is HEAD or HEADTAIL; front BODY/TAIL in IDLE SHALL be discarded (pointer advances, credit returned).
REQ-022: rt_en[v] SHALL be 1 exactly in the single cycle the VC is in RC; RC -> ACTIVE unconditionally next cycle.
REQ-023: sw_req[v] = (state ACTIVE) AND FIFO[v] non-empty.
REQ-024: sw_gnt[v] with sw_req[v]=1 SHALL dequeue front flit; next cycle odata = that flit, ovalid=1, ocredit[v]=1.
REQ-025: sw_gnt[v] with sw_req[v]=0 SHALL be ignored (no dequeue, no credit).
REQ-026: Multi-hot sw_gnt SHALL serve only the lowest-indexed requesting VC.
REQ-027: Dequeue of TAIL or HEADTAIL SHALL move that VC ACTIVE -> IDLE; else remain ACTIVE.
REQ-028: Latency: flit written to empty VC at edge t -> rt_en high cycle t+1 -> sw_req high cycle t+2 -> with immediate grant, odata/ovalid/ocredit in cycle t+3.
REQ-029: Discarded flits (REQ-021) SHALL not assert ovalid.

Reset
REQ-030: rst_=0 SHALL immediately clear all pointers, FSMs to IDLE, odata=0, ovalid=0, ocredit=0, rt_en=0, sw_req=0, ovf=0.
REQ-031: Reset mid-packet SHALL discard all buffered flits; no credits returned for them.

Structure
REQ-032: Flit type codes (HEAD, BODY, TAIL, HEADTAIL), type field positions and BUF_DEPTH default SHALL live in define.v.
REQ-033: One sub-module vc_fifo (single FIFO, write/read/full/empty/front) SHALL be instantiated VCH_NUM times; FSM and output regs in input_vc_buf.

Verification
REQ-034: HEADTAIL on VC0 into empty buffer at t, sw_gnt=01 whenever requested -> rt_en=01 at t+1, sw_req=01 at t+2, odata=flit, ocredit=01 at t+3, VC0 IDLE at t+3.
REQ-035: 4-flit packet H,B,B,T on VC1, grants every cycle -> four ovalid pulses in order, four ocredit[1] pulses, single rt_en[1] pulse.
REQ-036: 5 flits to VC0 with no grants, BUF_DEPTH=4 -> 5th dropped, ovf=1, occupancy 4; then write+grant same cycle on full VC0 -> both succeed, ovf stays 1.
REQ-037: Both VCs ACTIVE, sw_gnt=11 -> only VC0 dequeued, ocredit=01.
REQ-038: BODY arriving at IDLE VC0 -> discarded, ocredit=01, ovalid=0, rt_en=0.
REQ-039: rst_ low mid-packet with 3 flits buffered -> all outputs 0 immediately, sw_req=00 after release, no credits.
